sort3_stream_tx: RTL
====================

// Module: sort3_stream_tx
// PURPOSE
//  Accepts one triple of bytes (a,b,c) through a valid/ready handshake and sorts it with a two-stage
//  compare-exchange network. It then transmits the three values one beat per transfer, largest first
//  (DESCENDING=1), on a valid/ready stream tagged with the original index and a last flag.
//  Sits upstream of the min-compare datapath: it feeds ordered operands and serialises results.
// PARAMETERS
//  DW          8   data width of a, b, c and out_data (unsigned compare)
//  DESCENDING  1   1: emit max,mid,min; 0: emit min,mid,max
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst_n      in   1    reset, asynchronous, active-low
//  in_valid   in   1    triple on in_a/in_b/in_c is valid
//  in_ready   out  1    block can accept a triple (high only in IDLE)
//  in_a       in   DW   operand index 0
//  in_b       in   DW   operand index 1
//  in_c       in   DW   operand index 2
//  out_valid  out  1    out_data/out_idx/out_last valid
//  out_ready  in   1    downstream accepts current beat
//  out_data   out  DW   sorted value of current beat
//  out_idx    out  2    original index (0=a,1=b,2=c) of out_data
//  out_last   out  1    high on third (final) beat
//  busy       out  1    high in any state other than IDLE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_idx=0;
//    out_last=0; busy=0; all pipeline registers=0. Asserting rst_n mid-operation discards the triple.
//  FSM: IDLE -> S1 -> S2 -> EMIT -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready, capture {value,idx} x3 and go to S1.
//  S1: compare-exchange (0,1) and register the result.
//  S2: compare-exchange (1,2), then (0,1), combinationally; register the sorted triple; beat counter=0;
//    go to EMIT.
//  EMIT: out_valid=1; out_data/out_idx = sorted[beat]; out_last=(beat==2).
//    On out_valid&out_ready: beat++. The transfer on beat 2 returns the block to IDLE.
//    While out_ready=0, out_data/out_idx/out_last stay stable and out_valid stays high.
//  Latency: accept at edge T; out_valid first high after edge T+2, so first beat is at cycle T+3 with
//    out_ready=1. A triple takes 6 cycles with out_ready held high.
//  No overlap: in_ready=0 from the capture edge until the last beat transfers. in_ready returns high
//    the cycle after that. Throughput is 1 triple per 6 cycles at best.
//  Ties: the sort is stable. Equal values keep ascending original index, in both DESCENDING settings.
//    Swap only on strict greater/less.
//  Compare is unsigned, full DW. No arithmetic and no width growth. out_idx is 2 bits; value 3 never
//    appears.
//  in_valid while busy is ignored, and the data is not captured.
//  out_ready high outside EMIT has no effect.
// STRUCTURE
//  Package sort3_pkg holds: state enum {IDLE,S1,S2,EMIT} (2-bit); IDX_W=2; a typedef for the
//    {value,idx} element.
//  Sub-module sort3_cmp_swap (params DW, DESCENDING; inputs two elements; outputs ordered pair):
//    purely combinational. It is instantiated 3x: once in S1 and twice chained in S2.
//  Top module: FSM, capture/pipeline registers, beat counter, output mux.
// TESTING
//  1. Reset, then a=5,b=9,c=1, out_ready=1 -> beats (9,1),(5,0),(1,2 last); first beat at cycle T+3.
//  2. a=b=c=8'h7F -> idx order 0,1,2; data 7F each; out_last only on beat 3.
//  3. a=3,b=200,c=200, out_ready low 4 cycles in EMIT -> beat (200,1) held stable, then (200,2),(3,0).
//  4. Hold in_valid high with a=1,b=2,c=3, then a=4,b=5,c=6 during busy -> only the first triple is
//    emitted: (3,2),(2,1),(1,0).
//  5. Pulse rst_n low during EMIT beat 1 -> outputs zero at once; in_ready=1. The next triple 0,255,128
//    gives (255,1),(128,2),(0,0).
//  6. DESCENDING=0 with a=9,b=0,c=9 -> (0,1),(9,0),(9,2 last).

Source files
------------

// File: rtl/sort3_pkg.sv
// Shared types for the three-value sorting stream transmitter.
//   state_t : controller states (2-bit encoding)
//   IDX_W   : width of the original-index tag carried with every value
//   idx_t   : original index (0=a, 1=b, 2=c)
//   elem_t  : {value, idx} element layout for the default 8-bit data width.
//             Parameterised modules use the same layout as a flat vector:
//             value in the upper DW bits, idx in the lower IDX_W bits.
package sort3_pkg;

  localparam int IDX_W      = 2;
  localparam int DW_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    EMIT = 2'd3
  } state_t;

  typedef logic [IDX_W-1:0] idx_t;

  typedef struct packed {
    logic [DW_DEFAULT-1:0] value;
    idx_t                  idx;
  } elem_t;

endpackage

// File: rtl/sort3_cmp_swap.sv
// Combinational compare-exchange cell for {value,idx} elements.
//   a_i      : element in the earlier output position
//   b_i      : element in the later output position
//   first_o  : element that belongs in the earlier position
//   second_o : element that belongs in the later position
// The compare is unsigned over the full value field and swaps only on a
// strict inequality, so equal values keep their relative order.
module sort3_cmp_swap
  import sort3_pkg::*;
#(
  parameter int DW         = 8,
  parameter bit DESCENDING = 1'b1
) (
  input  logic [DW+IDX_W-1:0] a_i,
  input  logic [DW+IDX_W-1:0] b_i,
  output logic [DW+IDX_W-1:0] first_o,
  output logic [DW+IDX_W-1:0] second_o
);

  logic [DW-1:0] va;
  logic [DW-1:0] vb;
  logic          swap;

  assign va = a_i[DW+IDX_W-1:IDX_W];
  assign vb = b_i[DW+IDX_W-1:IDX_W];

  assign swap     = DESCENDING ? (va < vb) : (va > vb);
  assign first_o  = swap ? b_i : a_i;
  assign second_o = swap ? a_i : b_i;

endmodule

// File: rtl/sort3_stream_tx.sv
// Accepts a triple (a,b,c) over valid/ready, sorts it with a two-stage
// compare-exchange network and streams the values out one beat at a time,
// each tagged with its original index and a last flag on the third beat.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   in_valid / in_ready        : input handshake (ready only when idle)
//   in_a, in_b, in_c           : operands with index 0, 1, 2
//   out_valid / out_ready      : output handshake
//   out_data, out_idx, out_last: current sorted beat
//   busy                       : high whenever a triple is in flight
module sort3_stream_tx
  import sort3_pkg::*;
#(
  parameter int DW         = 8,
  parameter bit DESCENDING = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [DW-1:0] in_c,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output idx_t          out_idx,
  output logic          out_last,
  output logic          busy
);

  localparam int EW = DW + IDX_W;

  state_t        state_q, state_d;
  logic [1:0]    beat_q, beat_d;

  logic [EW-1:0] cap0_q, cap1_q, cap2_q;
  logic [EW-1:0] s1e0_q, s1e1_q, s1e2_q;
  logic [EW-1:0] srt0_q, srt1_q, srt2_q;

  logic [EW-1:0] s1e0_d, s1e1_d;
  logic [EW-1:0] m1, m2, f0, f1;
  logic [EW-1:0] cur;

  logic          accept;
  logic          beat_fire;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == EMIT);
  assign accept    = in_valid && in_ready;
  assign beat_fire = out_valid && out_ready;

  // First stage: order positions 0 and 1
  sort3_cmp_swap #(.DW(DW), .DESCENDING(DESCENDING)) u_cx01_a (
    .a_i      (cap0_q),
    .b_i      (cap1_q),
    .first_o  (s1e0_d),
    .second_o (s1e1_d)
  );

  // Second stage: positions 1/2 then 0/1 again, chained in one cycle
  sort3_cmp_swap #(.DW(DW), .DESCENDING(DESCENDING)) u_cx12 (
    .a_i      (s1e1_q),
    .b_i      (s1e2_q),
    .first_o  (m1),
    .second_o (m2)
  );

  sort3_cmp_swap #(.DW(DW), .DESCENDING(DESCENDING)) u_cx01_b (
    .a_i      (s1e0_q),
    .b_i      (m1),
    .first_o  (f0),
    .second_o (f1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: if (accept) state_d = S1;
      S1:   state_d = S2;
      S2: begin
        state_d = EMIT;
        beat_d  = 2'd0;
      end
      EMIT: begin
        if (beat_fire) begin
          if (beat_q == 2'd2) begin
            state_d = IDLE;
            beat_d  = 2'd0;
          end else begin
            beat_d = 2'(beat_q + 2'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Data registers only load in their own state, so the sorted triple is
  // frozen for the whole EMIT phase and survives any amount of backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap0_q <= '0;
      cap1_q <= '0;
      cap2_q <= '0;
      s1e0_q <= '0;
      s1e1_q <= '0;
      s1e2_q <= '0;
      srt0_q <= '0;
      srt1_q <= '0;
      srt2_q <= '0;
    end else begin
      if (accept) begin
        cap0_q <= {in_a, idx_t'(0)};
        cap1_q <= {in_b, idx_t'(1)};
        cap2_q <= {in_c, idx_t'(2)};
      end
      if (state_q == S1) begin
        s1e0_q <= s1e0_d;
        s1e1_q <= s1e1_d;
        s1e2_q <= cap2_q;
      end
      if (state_q == S2) begin
        srt0_q <= f0;
        srt1_q <= f1;
        srt2_q <= m2;
      end
    end
  end

  // Outputs read as zero whenever no beat is being offered
  always_comb begin
    cur      = '0;
    out_last = 1'b0;
    if (state_q == EMIT) begin
      case (beat_q)
        2'd0:    cur = srt0_q;
        2'd1:    cur = srt1_q;
        default: cur = srt2_q;
      endcase
      out_last = (beat_q == 2'd2);
    end
  end

  assign out_data = cur[EW-1:IDX_W];
  assign out_idx  = cur[IDX_W-1:0];

endmodule
